btn_event_gen: RTL

Upstream input-conditioning stage for the LED counter/brightness controller. It converts N raw, bouncy pushbuttons into clean single-cycle event pulses and stable levels. Per button it provides:
- a press event,
- a release event,
- optional hold-to-auto-repeat press events, so the counter and brightness logic can be stepped by holding a button.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_event_gen_if.sv | 40 ++++
 rtl/btn_event_fsm.sv | 146 ++++++++++++++
 rtl/btn_event_gen.sv | 41 ++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and default timing for the button event generator
//
// Purpose: per-button FSM state encoding and the 100 MHz default timing
// constants used as parameter defaults by btn_event_gen and its interface.
// Ports: none (package).
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } btn_state_e;

  localparam int unsigned DEF_N_BTN           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 300000;    // 3 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;  // 0.1 s
  localparam int unsigned DEF_CNT_W           = 26;

endpackage

// File: rtl/btn_event_gen_if.sv
// rtl/btn_event_gen_if.sv - button inputs and event outputs bundle
//
// Purpose: groups the per-button raw levels, repeat enables and the
// resulting event/level outputs.
// Ports (signals):
//   btn_raw     raw pushbutton levels, asynchronous, active-high
//   repeat_en   per-button auto-repeat enable, synchronous to clk
//   press_evt   one-cycle pulse on accepted press and each auto-repeat
//   release_evt one-cycle pulse on accepted release
//   btn_stable  debounced button level
// Modports: master drives buttons and consumes events, slave is the generator.
interface btn_event_gen_if
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN = DEF_N_BTN
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] repeat_en;
  logic [N_BTN-1:0] press_evt;
  logic [N_BTN-1:0] release_evt;
  logic [N_BTN-1:0] btn_stable;

  modport master (
    output btn_raw,
    output repeat_en,
    input  press_evt,
    input  release_evt,
    input  btn_stable
  );

  modport slave (
    input  btn_raw,
    input  repeat_en,
    output press_evt,
    output release_evt,
    output btn_stable
  );

endinterface

// File: rtl/btn_event_fsm.sv
// rtl/btn_event_fsm.sv - single-button synchronizer, debouncer and auto-repeat FSM
//
// Purpose: turns one raw bouncy button into registered press/release pulses
// and a debounced level, with optional hold-to-repeat press pulses.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   btn_raw       raw button level (asynchronous)
//   repeat_en     auto-repeat enable (synchronous)
//   press_evt     registered press / repeat pulse
//   release_evt   registered release pulse
//   btn_stable    registered debounced level
module btn_event_fsm
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic press_evt,
  output logic release_evt,
  output logic btn_stable
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             stable_q, stable_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      t_q       <= '0;
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      press_q   <= press_d;
      release_q <= release_d;
      stable_q  <= stable_d;
    end
  end

  always_comb begin
    sync1_d   = btn_raw;
    s_d       = sync1_q;
    state_d   = state_q;
    t_d       = t_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    stable_d  = stable_q;

    case (state_q)
      IDLE: begin
        stable_d = 1'b0;
        if (s_q) begin
          state_d = DEB_PRESS;
          t_d     = '0;
        end
      end

      DEB_PRESS: begin
        if (!s_q) begin
          state_d = IDLE;
        end else if (t_q == DEB_LAST) begin
          state_d  = HELD;
          t_d      = '0;
          press_d  = 1'b1;
          stable_d = 1'b1;
        end else begin
          t_d = t_q + 1'b1;
        end
      end

      HELD: begin
        if (!s_q) begin
          state_d = DEB_RELEASE;
          t_d     = '0;
        end else if (repeat_en && (t_q == DLY_LAST)) begin
          state_d = REPEAT;
          t_d     = '0;
          press_d = 1'b1;
        end else if (t_q != DLY_LAST) begin
          // Saturate so a late repeat_en fires on the next cycle.
          t_d = t_q + 1'b1;
        end
      end

      REPEAT: begin
        if (!s_q) begin
          state_d = DEB_RELEASE;
          t_d     = '0;
        end else if (repeat_en) begin
          if (t_q == PER_LAST) begin
            t_d     = '0;
            press_d = 1'b1;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end

      DEB_RELEASE: begin
        if (s_q) begin
          // Release bounce: back to HELD and restart the repeat delay.
          state_d = HELD;
          t_d     = '0;
        end else if (t_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          stable_d  = 1'b0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        t_d      = '0;
        stable_d = 1'b0;
      end
    endcase
  end

  assign press_evt   = press_q;
  assign release_evt = release_q;
  assign btn_stable  = stable_q;

endmodule

// File: rtl/btn_event_gen.sv
// rtl/btn_event_gen.sv - N-button debounced press/release/auto-repeat event generator
//
// Purpose: conditions N_BTN independent pushbuttons for the LED counter and
// brightness logic. Simultaneous events on several buttons are all reported
// in the same cycle.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   bus           btn_event_gen_if slave: btn_raw, repeat_en in;
//                 press_evt, release_evt, btn_stable out
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input logic             clk,
  input logic             reset_n,
  btn_event_gen_if.slave  bus
);

  for (genvar gi = 0; gi < int'(N_BTN); gi++) begin : g_btn
    btn_event_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_btn (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_raw     (bus.btn_raw[gi]),
      .repeat_en   (bus.repeat_en[gi]),
      .press_evt   (bus.press_evt[gi]),
      .release_evt (bus.release_evt[gi]),
      .btn_stable  (bus.btn_stable[gi])
    );
  end

endmodule
